// File: rtl/pkt_proc_if.sv
// Memory bus between pkt_proc (master) and the packet buffer (slave).
// Byte addressed; data is right-justified and big-endian within the used lanes.
interface pkt_proc_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              mem_ce_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [3:0]        mem_width_o;
  logic [DATA_W-1:0] mem_data_o;
  logic [DATA_W-1:0] mem_data_i;

  modport master (
    output mem_ce_o, mem_we_o, mem_addr_o, mem_width_o, mem_data_o,
    input  mem_data_i
  );

  modport slave (
    input  mem_ce_o, mem_we_o, mem_addr_o, mem_width_o, mem_data_o,
    output mem_data_i
  );
endinterface

// File: rtl/pkt_proc.sv
// IPv4 forwarding touch-up: checks EtherType, decrements TTL in place and
// patches the header checksum incrementally, one memory access per cycle.
module pkt_proc #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] pkt_addr_i,
  pkt_proc_if.master        mem,
  output logic              ready_o
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_RD_ETYPE,
    S_WT_ETYPE,
    S_RD_TTL,
    S_WT_TTL,
    S_WR_TTL,
    S_RD_CSUM,
    S_WT_CSUM,
    S_WR_CSUM,
    S_DONE
  } state_t;

  localparam logic [15:0] ETYPE_IPV4 = 16'h0800;

  state_t            r_state;
  state_t            w_next;
  logic              r_start;
  logic [ADDR_W-1:0] r_base;
  logic [7:0]        r_ttl;
  logic [15:0]       r_csum;
  logic              r_ready;

  logic              w_accept;
  logic [16:0]       w_csum_sum;
  logic [15:0]       w_csum_new;
  logic              w_ce;
  logic              w_we;
  logic [ADDR_W-1:0] w_addr;
  logic [3:0]        w_width;
  logic [DATA_W-1:0] w_data;
  logic              w_unused_data;

  assign w_accept = start_i && !r_start && (r_state == S_IDLE || r_state == S_DONE);

  // Decrementing TTL lowers the high byte of its header word by one, so the
  // stored (complemented) checksum rises by 0x0100 with end-around carry.
  assign w_csum_sum = {1'b0, mem.mem_data_i[15:0]} + 17'h00100;
  assign w_csum_new = w_csum_sum[15:0] + {15'b0, w_csum_sum[16]};

  assign w_unused_data = ^mem.mem_data_i[DATA_W-1:16];

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register sees pre-edge values.
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_start <= 1'b0;
      r_base  <= '0;
      r_ttl   <= '0;
      r_csum  <= '0;
      r_ready <= 1'b0;
    end else begin
      r_start <= start_i;
      if (w_accept)              r_base <= pkt_addr_i;
      if (r_state == S_WT_TTL)   r_ttl  <= mem.mem_data_i[7:0];
      if (r_state == S_WT_CSUM)  r_csum <= w_csum_new;
      r_ready <= (w_next == S_DONE);
    end
  end

  always_comb begin
    // NOTE: defaults first, so no path through the case can infer a latch.
    w_next  = r_state;
    w_ce    = 1'b0;
    w_we    = 1'b0;
    w_addr  = '0;
    w_width = '0;
    w_data  = '0;
    unique case (r_state)
      S_IDLE, S_DONE: if (w_accept) w_next = S_RD_ETYPE;
      S_RD_ETYPE: begin
        w_ce    = 1'b1;
        w_addr  = r_base + ADDR_W'(12);
        w_width = 4'd2;
        w_next  = S_WT_ETYPE;
      end
      S_WT_ETYPE: w_next = (mem.mem_data_i[15:0] == ETYPE_IPV4) ? S_RD_TTL : S_DONE;
      S_RD_TTL: begin
        w_ce    = 1'b1;
        w_addr  = r_base + ADDR_W'(22);
        w_width = 4'd1;
        w_next  = S_WT_TTL;
      end
      S_WT_TTL: w_next = (mem.mem_data_i[7:0] == 8'd0) ? S_DONE : S_WR_TTL;
      S_WR_TTL: begin
        w_ce    = 1'b1;
        w_we    = 1'b1;
        w_addr  = r_base + ADDR_W'(22);
        w_width = 4'd1;
        w_data  = DATA_W'(r_ttl - 8'd1);
        w_next  = S_RD_CSUM;
      end
      S_RD_CSUM: begin
        w_ce    = 1'b1;
        w_addr  = r_base + ADDR_W'(24);
        w_width = 4'd2;
        w_next  = S_WT_CSUM;
      end
      S_WT_CSUM: w_next = S_WR_CSUM;
      S_WR_CSUM: begin
        w_ce    = 1'b1;
        w_we    = 1'b1;
        w_addr  = r_base + ADDR_W'(24);
        w_width = 4'd2;
        w_data  = DATA_W'(r_csum);
        w_next  = S_DONE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // The bus is muted while rst is high so the reset cycle itself cannot
  // issue an access from the state being aborted.
  assign mem.mem_ce_o    = w_ce && !rst;
  assign mem.mem_we_o    = w_we && !rst;
  assign mem.mem_addr_o  = rst ? '0 : w_addr;
  assign mem.mem_width_o = rst ? '0 : w_width;
  assign mem.mem_data_o  = rst ? '0 : w_data;
  assign ready_o         = r_ready;

endmodule

// File: tb/tb_pkt_proc.sv
// Randomized bench for pkt_proc: a byte-array memory answers the bus and a
// packet-level model predicts the access list, final bytes and latency.
module tb_pkt_proc;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_i = 1'b0;
  logic [31:0] pkt_addr_i = '0;
  logic        ready_o;

  pkt_proc_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) mem_bus ();

  pkt_proc #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .pkt_addr_i (pkt_addr_i),
    .mem        (mem_bus.master),
    .ready_o    (ready_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  width;
    logic [31:0] data;
  } acc_t;

  acc_t       acc_log[$];
  acc_t       exp_acc[$];
  logic [7:0] mem_arr[256];
  logic [7:0] ref_mem[256];
  logic       pl_en = 1'b0;
  logic [7:0] pl_addr = '0;
  logic [7:0] pl_data = '0;
  int         idle_viol = 0;
  int         cyc = 0;
  int         exp_lat = 0;
  int         n_pass = 0;
  int         n_total = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Packet buffer: read data appears the cycle after the read request.
  always @(posedge clk) begin
    if (pl_en) mem_arr[pl_addr] <= pl_data;
    if (mem_bus.mem_ce_o && mem_bus.mem_we_o) begin
      if (mem_bus.mem_width_o == 4'd1) begin
        mem_arr[mem_bus.mem_addr_o[7:0]] <= mem_bus.mem_data_o[7:0];
      end else begin
        mem_arr[mem_bus.mem_addr_o[7:0]]           <= mem_bus.mem_data_o[15:8];
        mem_arr[8'(mem_bus.mem_addr_o[7:0] + 8'd1)] <= mem_bus.mem_data_o[7:0];
      end
    end
    if (mem_bus.mem_ce_o && !mem_bus.mem_we_o) begin
      if (mem_bus.mem_width_o == 4'd1)
        mem_bus.mem_data_i <= {24'b0, mem_arr[mem_bus.mem_addr_o[7:0]]};
      else
        mem_bus.mem_data_i <= {16'b0, mem_arr[mem_bus.mem_addr_o[7:0]],
                               mem_arr[8'(mem_bus.mem_addr_o[7:0] + 8'd1)]};
    end else begin
      mem_bus.mem_data_i <= $urandom;
    end
  end

  always @(negedge clk) begin
    if (mem_bus.mem_ce_o)
      acc_log.push_back(acc_t'{mem_bus.mem_we_o, mem_bus.mem_addr_o,
                               mem_bus.mem_width_o, mem_bus.mem_data_o});
    else if (mem_bus.mem_we_o || mem_bus.mem_addr_o != 0 ||
             mem_bus.mem_width_o != 0 || mem_bus.mem_data_o != 0)
      idle_viol <= idle_viol + 1;
  end

  task automatic poke(input logic [31:0] addr, input logic [7:0] d);
    @(negedge clk);
    pl_en = 1'b1; pl_addr = addr[7:0]; pl_data = d;
    ref_mem[addr[7:0]] = d;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic setup_pkt(input logic [31:0] base, input logic [15:0] etype,
                           input logic [7:0] ttl, input logic [15:0] hc);
    poke(base + 32'd12, etype[15:8]);
    poke(base + 32'd13, etype[7:0]);
    poke(base + 32'd22, ttl);
    poke(base + 32'd24, hc[15:8]);
    poke(base + 32'd25, hc[7:0]);
  endtask

  // Packet-level model: what a router does to one header, as a list of accesses.
  task automatic model_packet(input logic [31:0] base);
    logic [15:0] etype, hc;
    logic [7:0]  ttl;
    int          sum;
    exp_acc.delete();
    etype = {ref_mem[8'(base + 32'd12)], ref_mem[8'(base + 32'd13)]};
    exp_acc.push_back(acc_t'{1'b0, base + 32'd12, 4'd2, 32'd0});
    if (etype == 16'h0800) begin
      ttl = ref_mem[8'(base + 32'd22)];
      exp_acc.push_back(acc_t'{1'b0, base + 32'd22, 4'd1, 32'd0});
      if (ttl != 0) begin
        ttl = ttl - 8'd1;
        ref_mem[8'(base + 32'd22)] = ttl;
        exp_acc.push_back(acc_t'{1'b1, base + 32'd22, 4'd1, {24'b0, ttl}});
        hc = {ref_mem[8'(base + 32'd24)], ref_mem[8'(base + 32'd25)]};
        exp_acc.push_back(acc_t'{1'b0, base + 32'd24, 4'd2, 32'd0});
        sum = int'(hc) + 256;
        if (sum > 65535) sum = sum - 65535;
        hc = 16'(sum);
        ref_mem[8'(base + 32'd24)] = hc[15:8];
        ref_mem[8'(base + 32'd25)] = hc[7:0];
        exp_acc.push_back(acc_t'{1'b1, base + 32'd24, 4'd2, {16'b0, hc}});
      end
    end
    exp_lat = 0;
    foreach (exp_acc[i]) exp_lat += exp_acc[i].we ? 1 : 2;
  endtask

  task automatic wait_ready(input int acc_cyc, output int lat);
    while (!ready_o && (cyc - acc_cyc) < 40) begin
      @(posedge clk); #1;
    end
    lat = cyc - acc_cyc;
  endtask

  task automatic run_packet(input logic [31:0] base, output int ls, output int lat,
                            output logic rdy0);
    int acc_cyc;
    @(negedge clk); start_i = 1'b0;
    @(negedge clk); start_i = 1'b1; pkt_addr_i = base;
    ls = acc_log.size();
    @(posedge clk); #1;
    acc_cyc = cyc;
    rdy0 = ready_o;
    wait_ready(acc_cyc, lat);
  endtask

  task automatic compare_run(input string tag, input logic [31:0] base, input int ls,
                             input int lat, input logic rdy0);
    int offs[5] = '{12, 13, 22, 24, 25};
    logic [7:0] a;
    n_total++;
    if (rdy0 !== 1'b0) $display("FAIL %s ready_after_accept: got %b want 0", tag, rdy0);
    else n_pass++;
    n_total++;
    if (lat !== exp_lat) $display("FAIL %s latency: got %0d want %0d", tag, lat, exp_lat);
    else n_pass++;
    n_total++;
    if (acc_log.size() - ls !== exp_acc.size())
      $display("FAIL %s access_count: got %0d want %0d", tag, acc_log.size() - ls, exp_acc.size());
    else n_pass++;
    foreach (exp_acc[i]) begin
      if (ls + i < acc_log.size()) begin
        n_total++;
        if (acc_log[ls+i].we !== exp_acc[i].we || acc_log[ls+i].addr !== exp_acc[i].addr ||
            acc_log[ls+i].width !== exp_acc[i].width ||
            (exp_acc[i].we && acc_log[ls+i].data !== exp_acc[i].data))
          $display("FAIL %s access%0d: got we=%b a=%h w=%0d d=%h want we=%b a=%h w=%0d d=%h",
                   tag, i, acc_log[ls+i].we, acc_log[ls+i].addr, acc_log[ls+i].width,
                   acc_log[ls+i].data, exp_acc[i].we, exp_acc[i].addr, exp_acc[i].width,
                   exp_acc[i].data);
        else n_pass++;
      end
    end
    foreach (offs[k]) begin
      a = 8'(base + 32'(offs[k]));
      n_total++;
      if (mem_arr[a] !== ref_mem[a])
        $display("FAIL %s mem[%h]: got %h want %h", tag, a, mem_arr[a], ref_mem[a]);
      else n_pass++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start_i = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_total++;
    if (ready_o !== 1'b0) $display("FAIL reset_ready: got %b want 0", ready_o);
    else n_pass++;
    n_total++;
    if ({mem_bus.mem_ce_o, mem_bus.mem_we_o, mem_bus.mem_addr_o, mem_bus.mem_width_o,
         mem_bus.mem_data_o} !== '0)
      $display("FAIL reset_bus: got ce=%b we=%b a=%h w=%h d=%h want all 0", mem_bus.mem_ce_o,
               mem_bus.mem_we_o, mem_bus.mem_addr_o, mem_bus.mem_width_o, mem_bus.mem_data_o);
    else n_pass++;
    rst = 1'b0;
    repeat (4) @(negedge clk);
    n_total++;
    if (acc_log.size() !== 0) $display("FAIL idle_no_access: got %0d want 0", acc_log.size());
    else n_pass++;
  endtask

  task automatic test_ipv4();
    int ls, lat; logic rdy0;
    setup_pkt(32'd4, 16'h0800, 8'h40, 16'hB1E6);
    model_packet(32'd4);
    run_packet(32'd4, ls, lat, rdy0);
    compare_run("ipv4", 32'd4, ls, lat, rdy0);
    n_total++;
    if (mem_arr[26] !== 8'h3F || {mem_arr[28], mem_arr[29]} !== 16'hB2E6 || lat !== 8)
      $display("FAIL ipv4_fixed: got ttl=%h hc=%h lat=%0d want 3f b2e6 8",
               mem_arr[26], {mem_arr[28], mem_arr[29]}, lat);
    else n_pass++;
  endtask

  task automatic test_non_ipv4();
    int ls, lat; logic rdy0;
    setup_pkt(32'd4, 16'h86DD, 8'h40, 16'($urandom));
    model_packet(32'd4);
    run_packet(32'd4, ls, lat, rdy0);
    compare_run("non_ipv4", 32'd4, ls, lat, rdy0);
    n_total++;
    if (lat !== 2 || acc_log.size() - ls !== 1 || acc_log[ls].addr !== 32'd16)
      $display("FAIL non_ipv4_fixed: got lat=%0d n=%0d want 2 1 at 16", lat, acc_log.size() - ls);
    else n_pass++;
  endtask

  task automatic test_ttl_zero();
    int ls, lat; logic rdy0;
    setup_pkt(32'd48, 16'h0800, 8'h00, 16'h1234);
    model_packet(32'd48);
    run_packet(32'd48, ls, lat, rdy0);
    compare_run("ttl_zero", 32'd48, ls, lat, rdy0);
  endtask

  task automatic test_end_around();
    int ls, lat; logic rdy0;
    setup_pkt(32'd96, 16'h0800, 8'h01, 16'hFF00);
    model_packet(32'd96);
    run_packet(32'd96, ls, lat, rdy0);
    compare_run("end_around", 32'd96, ls, lat, rdy0);
    n_total++;
    if (mem_arr[118] !== 8'h00 || {mem_arr[120], mem_arr[121]} !== 16'h0001)
      $display("FAIL end_around_fixed: got ttl=%h hc=%h want 00 0001",
               mem_arr[118], {mem_arr[120], mem_arr[121]});
    else n_pass++;
  endtask

  task automatic test_start_level();
    int ls, lat, ls2; logic rdy0;
    setup_pkt(32'd40, 16'h0800, 8'h10, 16'h4321);
    model_packet(32'd40);
    run_packet(32'd40, ls, lat, rdy0);
    compare_run("level_first", 32'd40, ls, lat, rdy0);
    ls2 = acc_log.size();
    repeat (12) @(posedge clk);
    @(negedge clk);
    n_total++;
    if (acc_log.size() !== ls2 || ready_o !== 1'b1)
      $display("FAIL level_held: got %0d new accesses ready=%b want 0 1",
               acc_log.size() - ls2, ready_o);
    else n_pass++;
    model_packet(32'd40);
    run_packet(32'd40, ls, lat, rdy0);
    compare_run("level_retoggle", 32'd40, ls, lat, rdy0);
    n_total++;
    if (mem_arr[62] !== 8'h0E) $display("FAIL level_ttl_twice: got %h want 0e", mem_arr[62]);
    else n_pass++;
  endtask

  task automatic test_ignore_busy();
    int ls, lat, acc_cyc; logic rdy0;
    setup_pkt(32'd128, 16'h0800, 8'h33, 16'h00FF);
    model_packet(32'd128);
    @(negedge clk); start_i = 1'b0;
    @(negedge clk); start_i = 1'b1; pkt_addr_i = 32'd128;
    ls = acc_log.size();
    @(posedge clk); #1;
    acc_cyc = cyc; rdy0 = ready_o;
    @(negedge clk); start_i = 1'b0;
    @(negedge clk); start_i = 1'b1; pkt_addr_i = 32'd200;
    wait_ready(acc_cyc, lat);
    compare_run("ignore_busy", 32'd128, ls, lat, rdy0);
  endtask

  task automatic test_reset_mid();
    int ls, lat; logic rdy0;
    logic [7:0] ttl_before;
    setup_pkt(32'd160, 16'h0800, 8'h22, 16'h5555);
    ttl_before = ref_mem[182];
    @(negedge clk); start_i = 1'b0;
    @(negedge clk); start_i = 1'b1; pkt_addr_i = 32'd160;
    ls = acc_log.size();
    @(posedge clk);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    n_total++;
    if (mem_bus.mem_ce_o !== 1'b0 || mem_bus.mem_we_o !== 1'b0)
      $display("FAIL rst_cycle_write: got ce=%b we=%b want 0 0", mem_bus.mem_ce_o, mem_bus.mem_we_o);
    else n_pass++;
    @(negedge clk); start_i = 1'b0;
    @(negedge clk); rst = 1'b0;
    repeat (15) @(negedge clk);
    n_total++;
    if (acc_log.size() - ls !== 2 || acc_log[ls].we !== 1'b0 || acc_log[ls+1].we !== 1'b0)
      $display("FAIL rst_mid_accesses: got %0d accesses want 2 reads", acc_log.size() - ls);
    else n_pass++;
    n_total++;
    if (ready_o !== 1'b0 || mem_arr[182] !== ttl_before)
      $display("FAIL rst_mid_state: got ready=%b ttl=%h want 0 %h", ready_o, mem_arr[182], ttl_before);
    else n_pass++;
  endtask

  task automatic test_reset_start_high();
    int ls, lat, acc_cyc;
    setup_pkt(32'd64, 16'h0800, 8'h80, 16'hA0A0);
    model_packet(32'd64);
    @(negedge clk); rst = 1'b1; start_i = 1'b1; pkt_addr_i = 32'd64;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    ls = acc_log.size();
    @(posedge clk); #1;
    acc_cyc = cyc;
    wait_ready(acc_cyc, lat);
    compare_run("start_at_reset", 32'd64, ls, lat, 1'b0);
  endtask

  task automatic test_addr_wrap();
    int ls, lat; logic rdy0;
    setup_pkt(32'hFFFF_FFF0, 16'h0800, 8'h05, 16'hFE80);
    model_packet(32'hFFFF_FFF0);
    run_packet(32'hFFFF_FFF0, ls, lat, rdy0);
    compare_run("addr_wrap", 32'hFFFF_FFF0, ls, lat, rdy0);
  endtask

  task automatic test_random();
    int ls, lat; logic rdy0;
    logic [31:0] base;
    logic [15:0] etype;
    logic [7:0]  ttl;
    for (int i = 0; i < 8; i++) begin
      base  = 32'($urandom_range(0, 50)) * 32'd4;
      etype = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'h0800;
      case ($urandom_range(0, 3))
        0:       ttl = 8'h00;
        1:       ttl = 8'h01;
        default: ttl = 8'($urandom);
      endcase
      setup_pkt(base, etype, ttl, 16'($urandom));
      model_packet(base);
      run_packet(base, ls, lat, rdy0);
      compare_run($sformatf("random%0d", i), base, ls, lat, rdy0);
    end
  endtask

  task automatic test_bus_idle();
    n_total++;
    if (idle_viol !== 0) $display("FAIL bus_idle_zero: got %0d violations want 0", idle_viol);
    else n_pass++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_ipv4();
    test_non_ipv4();
    test_ttl_zero();
    test_end_around();
    test_start_level();
    test_ignore_busy();
    test_reset_mid();
    test_reset_start_high();
    test_addr_wrap();
    test_random();
    test_bus_idle();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
